demux16_dist: RTL
=================

DEMUX16_DIST -- requirements
Module: demux16_dist

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning data width per channel.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port in_vld  input  1  upstream item valid.
REQ-005 SHALL have port in_rdy  output  1  block accepts item this cycle.
REQ-006 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-007 SHALL have port in_sel  input  4  destination channel index 0..15.
REQ-008 SHALL have port out_vld  output  16  per-channel valid, bit i = channel i.
REQ-009 SHALL have port out_rdy  input  16  per-channel downstream ready.
REQ-010 SHALL have port out_data  output  16*WIDTH  channel i payload at bits [i*WIDTH +: WIDTH].

Function
REQ-011 SHALL hold one registered entry (slot) per channel: valid bit plus WIDTH-bit data.
REQ-012 SHALL drive in_rdy = !slot_vld[in_sel] || out_rdy[in_sel]; in_rdy is independent of in_vld.
REQ-013 SHALL accept an item when in_vld && in_rdy: it writes in_data into slot in_sel, and out_vld[in_sel] is 1 on the next cycle (latency 1).
REQ-014 SHALL drain slot i when out_vld[i] && out_rdy[i]; out_vld[i] then clears next cycle unless a refill occurs.
REQ-015 SHALL, on a simultaneous drain and refill of the same slot, load new data and keep out_vld[i]=1 (full throughput, no bubble).
REQ-016 SHALL keep out_data[i] stable while out_vld[i]=1 and out_rdy[i]=0.
REQ-017 SHALL leave channels other than in_sel unaffected by an accept; drains on any channels proceed in parallel.
REQ-018 SHALL not accept when the target slot is full and its out_rdy is 0; it SHALL NOT drop or overwrite data.
REQ-019 SHALL ignore in_sel and in_data when in_vld=0.

Reset
REQ-020 SHALL, with rst_n=0 at a clock edge, clear all slot valid bits and set slot data to 0: out_vld=16'h0000, out_data=0.
REQ-021 SHALL discard buffered items and ignore any handshake in progress when reset is asserted mid-operation; in_rdy=1 on the first cycle after reset.

Configuration
REQ-022 SHALL compile the broadcast feature only when macro DEMUX16_BCAST_EN is defined.
REQ-023 SHALL, with DEMUX16_BCAST_EN defined, add input in_bcast (1 bit). An accept with in_bcast=1 loads all 16 slots. In that case in_rdy = AND over i of (!slot_vld[i] || out_rdy[i]), and in_sel is ignored.
REQ-024 SHALL, without DEMUX16_BCAST_EN, have no in_bcast port, and the behaviour is exactly REQ-012..REQ-019.

Structure
REQ-025 SHALL place the constants NUM_CH=16 and SEL_W=4 in shared package mux_pkg.
REQ-026 SHALL implement each channel as sub-module demux_slot (one-entry valid/ready register slice, WIDTH parameter), instantiated 16 times by generate.

Verification
REQ-027 Single item: in_sel=5, in_data=4'hA, out_rdy=all 1 -> out_vld=16'h0020 with out_data[5]=4'hA one cycle later, then 0.
REQ-028 Backpressure: fill channel 3 with out_rdy[3]=0, then present another item to channel 3 -> in_rdy=0, slot holds the first value; raise out_rdy[3] -> second item accepted the same cycle and appears next cycle.
REQ-029 Streaming: send 0..15 to channels 0..15 on consecutive cycles with out_rdy=all 1 -> in_rdy held at 1, each channel pulses once with its value.
REQ-030 Same-slot drain and refill: channel 7 full with out_rdy[7]=1, new item for channel 7 -> out_vld[7] stays 1, data updates, no bubble.
REQ-031 Reset mid-operation: with 4 slots full, assert rst_n=0 for one cycle -> out_vld=0, out_data=0, in_rdy=1.
REQ-032 Broadcast (DEMUX16_BCAST_EN defined): in_bcast=1, data 4'h3, slot 2 full with out_rdy[2]=0 -> in_rdy=0; release out_rdy[2] -> accept, out_vld=16'hFFFF and all 16 channels carry 4'h3.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the 16-channel demultiplexer.
package mux_pkg;

    localparam int NUM_CH = 16;
    localparam int SEL_W  = 4;

    // One-hot decode of a channel index.
    function automatic logic [NUM_CH-1:0] sel_decode(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] dec;
        dec      = {NUM_CH{1'b0}};
        dec[sel] = 1'b1;
        return dec;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready register slice: holds a single item per channel.
// A write and a drain in the same cycle reload the slot without a bubble.
module demux_slot #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rdy_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o
);

    logic             vld_q;
    logic             vld_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next-state: a write always wins; a drain without a write empties the slot.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (wr_en_i) begin
            vld_d  = 1'b1;
            data_d = wr_data_i;
        end else if (vld_q && rdy_i) begin
            vld_d = 1'b0;
        end else begin
            vld_d = vld_q;
        end
    end

    // Slot state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= {WIDTH{1'b0}};
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/demux16_dist.sv
// 16-way valid/ready demultiplexer with one registered slot per channel.
// Optional broadcast input in_bcast is compiled in with DEMUX16_BCAST_EN.
module demux16_dist
    import mux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]        in_sel,
`ifdef DEMUX16_BCAST_EN
    input  logic                    in_bcast,
`endif
    output logic [NUM_CH-1:0]       out_vld,
    input  logic [NUM_CH-1:0]       out_rdy,
    output logic [NUM_CH*WIDTH-1:0] out_data
);

    logic [NUM_CH-1:0] slot_free_s;
    logic [NUM_CH-1:0] target_s;
    logic [NUM_CH-1:0] wr_en_s;
    logic              rdy_s;
    logic              bcast_s;

`ifdef DEMUX16_BCAST_EN
    assign bcast_s = in_bcast;
`else
    assign bcast_s = 1'b0;
`endif

    // A slot can take a new item if it is empty or being drained this cycle.
    assign slot_free_s = ~out_vld | out_rdy;

    // Ready and write-enable decode; ready never depends on in_vld.
    always_comb begin
        rdy_s    = 1'b0;
        target_s = {NUM_CH{1'b0}};
        wr_en_s  = {NUM_CH{1'b0}};
        if (bcast_s) begin
            rdy_s    = &slot_free_s;
            target_s = {NUM_CH{1'b1}};
        end else begin
            rdy_s    = slot_free_s[in_sel];
            target_s = sel_decode(in_sel);
        end
        if (in_vld && rdy_s) begin
            wr_en_s = target_s;
        end else begin
            wr_en_s = {NUM_CH{1'b0}};
        end
    end

    assign in_rdy = rdy_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en_i  (wr_en_s[g]),
            .wr_data_i(in_data),
            .rdy_i    (out_rdy[g]),
            .vld_o    (out_vld[g]),
            .data_o   (out_data[g*WIDTH +: WIDTH])
        );
    end

endmodule
